// File: rtl/muldiv_pkg.sv
// Shared types and op-decode helpers for the RV64M multiply/divide unit.
// Optional early-out build: MULDIV_EARLY_OUT_EN.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;

    function automatic logic is_div(muldiv_op_e op);
        logic [2:0] c;
        c = op;
        return c[2];
    endfunction

    function automatic logic is_rem(muldiv_op_e op);
        logic [2:0] c;
        c = op;
        return c[2] & c[1];
    endfunction

    function automatic logic is_mulh(muldiv_op_e op);
        logic [2:0] c;
        c = op;
        return !c[2] && (c[1:0] != 2'b00);
    endfunction

    function automatic logic a_signed(muldiv_op_e op);
        return (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
    endfunction

    function automatic logic b_signed(muldiv_op_e op);
        return (op == MULH) || (op == DIV) || (op == REM);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the decode path, the unit and writeback.
// master drives requests and out_ready; slave is the unit.
interface muldiv_if
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) ();

    logic             in_valid;
    logic             in_ready;
    muldiv_op_e       in_op;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );

endinterface

// File: rtl/muldiv_sign_fix.sv
// Sign handling around the unsigned iterative core: OUT_SIDE=0 takes operand
// magnitudes, OUT_SIDE=1 re-applies signs and selects the architected result.
module muldiv_sign_fix
    import muldiv_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter bit OUT_SIDE = 1'b0
) (
    input  muldiv_op_e        op_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    input  logic [2*XLEN-1:0] prod_i,
    input  logic              a_neg_i,
    input  logic              b_neg_i,
    input  logic              div0_i,
    output logic [XLEN-1:0]   a_o,
    output logic [XLEN-1:0]   b_o,
    output logic              a_neg_o,
    output logic              b_neg_o,
    output logic              div0_o
);

    generate
        if (!OUT_SIDE) begin : g_in
            logic unused_in;
            assign unused_in = ^{prod_i, a_neg_i, b_neg_i, div0_i};

            always_comb begin
                a_neg_o = a_signed(op_i) && a_i[XLEN-1];
                b_neg_o = b_signed(op_i) && b_i[XLEN-1];
                a_o     = a_neg_o ? -a_i : a_i;
                b_o     = b_neg_o ? -b_i : b_i;
                div0_o  = is_div(op_i) && (b_i == '0);
            end
        end else begin : g_out
            logic [2*XLEN-1:0] prod_fix;
            logic [XLEN-1:0]   quo_fix;
            logic [XLEN-1:0]   rem_fix;

            always_comb begin
                prod_fix = (a_neg_i ^ b_neg_i) ? -prod_i : prod_i;
                // x/0 must stay all ones even for a negative dividend
                quo_fix  = ((a_neg_i ^ b_neg_i) && !div0_i) ? -a_i : a_i;
                rem_fix  = a_neg_i ? -b_i : b_i;
                a_o      = '0;
                b_o      = '0;
                a_neg_o  = 1'b0;
                b_neg_o  = 1'b0;
                div0_o   = 1'b0;
                unique case (1'b1)
                    op_i == MUL:                   a_o = prod_fix[XLEN-1:0];
                    is_mulh(op_i):                 a_o = prod_fix[2*XLEN-1:XLEN];
                    is_div(op_i) && !is_rem(op_i): a_o = quo_fix;
                    is_rem(op_i):                  a_o = rem_fix;
                    default:                       a_o = '0;
                endcase
            end
        end
    endgenerate

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit: shift-add multiply, restoring divide.
// Define MULDIV_EARLY_OUT_EN to finish zero/overflow cases on the accept edge.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     flush,
    muldiv_if.slave  bus
);

    localparam int CW = $clog2(XLEN);

    muldiv_state_e     state_q, state_d;
    muldiv_op_e        op_q, op_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              a_neg_q, a_neg_d;
    logic              b_neg_q, b_neg_d;
    logic              div0_q, div0_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [XLEN-1:0]   res_q, res_d;

    logic              in_ready;
    logic              accept;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic              in_a_neg, in_b_neg, in_div0;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_sh, rem_diff;
    logic [2*XLEN-1:0] acc_step;
    logic [XLEN-1:0]   fix_res;
    logic [XLEN-1:0]   unused_b;
    logic              unused_an, unused_bn, unused_d0;

    assign in_ready       = (state_q == IDLE) && !rst;
    assign accept         = bus.in_valid && in_ready && !flush;
    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = (state_q == DONE);
    assign bus.out_result = res_q;
    assign bus.out_tag    = tag_q;

    muldiv_sign_fix #(.XLEN(XLEN), .OUT_SIDE(1'b0)) u_fix_in (
        .op_i    (bus.in_op),
        .a_i     (bus.in_a),
        .b_i     (bus.in_b),
        .prod_i  ('0),
        .a_neg_i (1'b0),
        .b_neg_i (1'b0),
        .div0_i  (1'b0),
        .a_o     (abs_a),
        .b_o     (abs_b),
        .a_neg_o (in_a_neg),
        .b_neg_o (in_b_neg),
        .div0_o  (in_div0)
    );

    // Low half of acc: multiplier / quotient; high half: partial product / remainder
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]}
                 + (acc_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        rem_diff = rem_sh - {1'b0, opnd_q};
        if (!is_div(op_q)) begin
            acc_step = {mul_sum, acc_q[XLEN-1:1]};
        end else if (rem_diff[XLEN]) begin
            acc_step = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
            acc_step = {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end
    end

    muldiv_sign_fix #(.XLEN(XLEN), .OUT_SIDE(1'b1)) u_fix_out (
        .op_i    (op_q),
        .a_i     (acc_step[XLEN-1:0]),
        .b_i     (acc_step[2*XLEN-1:XLEN]),
        .prod_i  (acc_step),
        .a_neg_i (a_neg_q),
        .b_neg_i (b_neg_q),
        .div0_i  (div0_q),
        .a_o     (fix_res),
        .b_o     (unused_b),
        .a_neg_o (unused_an),
        .b_neg_o (unused_bn),
        .div0_o  (unused_d0)
    );

`ifdef MULDIV_EARLY_OUT_EN
    logic            early;
    logic [XLEN-1:0] early_res;

    always_comb begin
        logic ovf;
        logic mz;
        ovf = is_div(bus.in_op) && a_signed(bus.in_op)
            && (bus.in_a == {1'b1, {(XLEN-1){1'b0}}})
            && (bus.in_b == '1);
        mz  = !is_div(bus.in_op)
            && ((bus.in_a == '0) || (bus.in_b == '0));
        early     = in_div0 || ovf || mz;
        early_res = '0;
        if (in_div0) begin
            early_res = is_rem(bus.in_op) ? bus.in_a : '1;
        end else if (ovf) begin
            early_res = is_rem(bus.in_op) ? '0 : bus.in_a;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        tag_d   = tag_q;
        a_neg_d = a_neg_q;
        b_neg_d = b_neg_q;
        div0_d  = div0_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        res_d   = res_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = CALC;
                    op_d    = bus.in_op;
                    tag_d   = bus.in_tag;
                    a_neg_d = in_a_neg;
                    b_neg_d = in_b_neg;
                    div0_d  = in_div0;
                    cnt_d   = CW'(XLEN - 1);
                    acc_d   = is_div(bus.in_op)
                            ? {{XLEN{1'b0}}, abs_a}
                            : {{XLEN{1'b0}}, abs_b};
                    opnd_d  = is_div(bus.in_op) ? abs_b : abs_a;
`ifdef MULDIV_EARLY_OUT_EN
                    if (early) begin
                        state_d = DONE;
                        res_d   = early_res;
                    end
`endif
                end
            end
            CALC: begin
                acc_d = acc_step;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    res_d   = fix_res;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= MUL;
            tag_q   <= '0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            div0_q  <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            tag_q   <= tag_d;
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
            div0_q  <= div0_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            res_q   <= res_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases, back-pressure,
// flush/reset abort and randomized ops against a 128-bit arithmetic model.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int XLEN  = 64;
    localparam int TAG_W = 5;
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    localparam logic [63:0] XMIN = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk;
    logic rst;
    logic flush;
    int   n_checks;
    int   n_fail;

    muldiv_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_op(input muldiv_op_e op,
                                           input logic [63:0] a,
                                           input logic [63:0] b);
        logic signed [127:0] sp;
        logic [127:0]        up;
        logic signed [63:0]  sa;
        logic signed [63:0]  sb;
        logic                ovf;
        sa  = a;
        sb  = b;
        ovf = (a == XMIN) && (b == ONES);
        case (op)
            MUL: return a * b;
            MULH: begin
                sp = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
                return sp[127:64];
            end
            MULHSU: begin
                sp = $signed({{64{a[63]}}, a}) * $signed({64'b0, b});
                return sp[127:64];
            end
            MULHU: begin
                up = {64'b0, a} * {64'b0, b};
                return up[127:64];
            end
            DIV:  return (b == 0) ? ONES : (ovf ? a : 64'(sa / sb));
            DIVU: return (b == 0) ? ONES : a / b;
            REM:  return (b == 0) ? a : (ovf ? 64'd0 : 64'(sa % sb));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input muldiv_op_e op,
                                   input logic [63:0] a,
                                   input logic [63:0] b);
        logic dv;
        logic special;
        dv      = (op == DIV) || (op == DIVU) || (op == REM) || (op == REMU);
        special = (dv && b == 0)
               || ((op == DIV || op == REM) && a == XMIN && b == ONES)
               || (!dv && (a == 0 || b == 0));
        return (EARLY && special) ? 0 : XLEN;
    endfunction

    task automatic send(input muldiv_op_e op, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] tg);
        @(negedge clk);
        check("ready_before", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = tg;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("accepted", 64'(bus.in_ready), 64'd0);
    endtask

    task automatic wait_done(input logic [63:0] exp, input int lat,
                             input logic [4:0] tg);
        int k;
        k = 0;
        while (!bus.out_valid && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("latency", 64'(k), 64'(lat));
        check("result", bus.out_result, exp);
        check("tag", 64'(bus.out_tag), 64'(tg));
        check("busy_done", 64'(bus.in_ready), 64'd0);
    endtask

    task automatic take();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("ready_after", 64'(bus.in_ready), 64'd1);
        check("valid_drop", 64'(bus.out_valid), 64'd0);
    endtask

    task automatic directed(input muldiv_op_e op, input logic [63:0] a,
                            input logic [63:0] b, input logic [63:0] exp);
        logic [4:0] tg;
        tg = 5'($urandom_range(0, 31));
        send(op, a, b, tg);
        wait_done(exp, exp_lat(op, a, b), tg);
        take();
    endtask

    task automatic quiet(input string tag);
        int seen;
        seen = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen++;
        end
        check(tag, 64'(seen), 64'd0);
    endtask

    function automatic logic [63:0] rnd_opnd();
        case ($urandom_range(0, 9))
            0: return 64'd0;
            1: return ONES;
            2: return XMIN;
            3: return 64'($urandom_range(0, 20));
            4: return -64'($urandom_range(1, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] ra, rb, hold_res;
        logic [4:0]  rt;
        muldiv_op_e  rop;

        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = MUL;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(bus.in_ready), 64'd0);
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_result", bus.out_result, 64'd0);
        check("rst_tag", 64'(bus.out_tag), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_ready", 64'(bus.in_ready), 64'd1);

        directed(MUL, 64'd7, -64'd3, 64'hFFFF_FFFF_FFFF_FFEB);
        directed(MULHU, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE);
        directed(MULH, ONES, ONES, 64'd0);
        directed(MULHSU, ONES, 64'd2, ONES);
        directed(DIV, -64'd7, 64'd2, -64'd3);
        directed(REM, -64'd7, 64'd2, ONES);
        directed(DIVU, 64'd7, 64'd0, ONES);
        directed(REMU, 64'd7, 64'd0, 64'd7);
        directed(DIV, -64'd7, 64'd0, ONES);
        directed(REM, -64'd7, 64'd0, -64'd7);
        directed(DIV, XMIN, ONES, XMIN);
        directed(REM, XMIN, ONES, 64'd0);
        directed(MUL, 64'd0, 64'd12345, 64'd0);

        send(DIVU, 64'd1000, 64'd7, 5'd19);
        wait_done(64'd142, XLEN, 5'd19);
        hold_res = 64'd142;
        repeat (10) begin
            @(posedge clk);
            #1;
            check("bp_valid", 64'(bus.out_valid), 64'd1);
            check("bp_result", bus.out_result, hold_res);
            check("bp_tag", 64'(bus.out_tag), 64'd19);
            check("bp_ready", 64'(bus.in_ready), 64'd0);
        end
        take();
        send(MUL, 64'd6, 64'd9, 5'd3);
        wait_done(64'd54, XLEN, 5'd3);
        take();

        send(MUL, 64'd5, 64'd9, 5'd1);
        repeat (19) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_ready", 64'(bus.in_ready), 64'd1);
        check("flush_valid", 64'(bus.out_valid), 64'd0);
        quiet("flush_quiet");

        send(DIV, 64'd99, 64'd4, 5'd2);
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        check("rst_mid_ready2", 64'(bus.in_ready), 64'd0);
        check("rst_mid_valid", 64'(bus.out_valid), 64'd0);
        check("rst_mid_result", bus.out_result, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_rel_ready", 64'(bus.in_ready), 64'd1);
        quiet("rst_quiet");

        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = MUL;
        bus.in_a     = 64'd3;
        bus.in_b     = 64'd4;
        flush        = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        flush        = 1'b0;
        check("flush_noacc", 64'(bus.in_ready), 64'd1);
        quiet("flush_noacc_quiet");

        for (int i = 0; i < 40; i++) begin
            rop = muldiv_op_e'($urandom_range(0, 7));
            ra  = rnd_opnd();
            rb  = rnd_opnd();
            rt  = 5'($urandom_range(0, 31));
            send(rop, ra, rb, rt);
            wait_done(ref_op(rop, ra, rb), exp_lat(rop, ra, rb), rt);
            take();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
